seq_shifter: RTL and testbench

Parametrised multi-cycle barrel-shift engine for the neuromorphic interface datapath. It shifts or rotates a WIDTH-bit operand by a run-time amount in STEP bits per clock and reports the last bit shifted out plus a zero flag. It replaces single-purpose fixed-width shifters in membrane-potential scaling and decay paths and exchanges operands and results over valid/ready handshakes.

---
 rtl/seq_shifter.sv | 164 ++++++++++++++++
 tb/tb_seq_shifter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
`default_nettype none
// ============================================================================
// Module      : seq_shifter
// Description : Multi-cycle shift/rotate engine, STEP bits per clock, with
//               valid/ready command and result handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [2:0]       c_lsl   = 3'd0;
    localparam logic [2:0]       c_lsr   = 3'd1;
    localparam logic [2:0]       c_asr   = 3'd2;
    localparam logic [2:0]       c_rol   = 3'd3;
    localparam logic [2:0]       c_ror   = 3'd4;
    localparam logic [AW:0]      c_width = (AW+1)'(WIDTH);
    localparam logic [AW:0]      c_step  = (AW+1)'(STEP);
    localparam logic [WIDTH-1:0] c_one   = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_data;
    logic [AW-1:0]    r_cnt;
    logic [2:0]       r_mode;
    logic             r_carry;
    logic             r_err;

    logic [AW:0]      w_k;
    logic [AW-1:0]    w_cnt_next;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_shifted;
    logic             w_carry;
    logic             w_illegal;

    assign w_illegal = (in_mode > c_ror);

    // One step of the latched operation; k is the final partial step when count < STEP.
    always_comb begin
        w_k        = ({1'b0, r_cnt} >= c_step) ? c_step : {1'b0, r_cnt};
        w_cnt_next = r_cnt - w_k[AW-1:0];
        w_rol      = (r_data << w_k) | (r_data >> (c_width - w_k));
        w_ror      = (r_data >> w_k) | (r_data << (c_width - w_k));
        w_shifted  = r_data;
        w_carry    = 1'b0;
        case (r_mode)
            c_lsl: begin
                w_shifted = r_data << w_k;
                w_carry   = |(r_data & (c_one << (c_width - w_k)));
            end
            c_lsr: begin
                w_shifted = r_data >> w_k;
                w_carry   = |(r_data & (c_one << (w_k - 1'b1)));
            end
            c_asr: begin
                w_shifted = $signed(r_data) >>> w_k;
                w_carry   = |(r_data & (c_one << (w_k - 1'b1)));
            end
            c_rol: begin
                w_shifted = w_rol;
                w_carry   = |(w_rol & (c_one << (w_k - 1'b1)));
            end
            c_ror: begin
                w_shifted = w_ror;
                w_carry   = |(w_ror & (c_one << (c_width - w_k)));
            end
            default: begin
                w_shifted = r_data;
                w_carry   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next_state = (w_illegal || (in_amt == '0)) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_cnt_next == '0) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_cnt   <= '0;
            r_mode  <= c_lsl;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_cnt   <= w_illegal ? '0 : in_amt;
                        r_mode  <= in_mode;
                        r_carry <= 1'b0;
                        r_err   <= w_illegal;
                    end
                end
                S_SHIFT: begin
                    r_data  <= w_shifted;
                    r_cnt   <= w_cnt_next;
                    r_carry <= w_carry;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_data  = r_data;
    assign out_carry = r_carry;
    assign out_zero  = ~|r_data;
    assign out_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_shifter
// Description : Self-checking bench for seq_shifter; unit 0 runs STEP=1,
//               unit 1 runs STEP=4, both WIDTH=32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_shifter;

    localparam logic [2:0] LSL = 3'd0;
    localparam logic [2:0] LSR = 3'd1;
    localparam logic [2:0] ASR = 3'd2;
    localparam logic [2:0] ROL = 3'd3;
    localparam logic [2:0] ROR = 3'd4;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       in_valid;
    logic [1:0]       out_ready;
    logic [1:0][31:0] in_data;
    logic [1:0][4:0]  in_amt;
    logic [1:0][2:0]  in_mode;
    wire  [1:0]       in_ready;
    wire  [1:0]       out_valid;
    wire  [1:0]       out_carry;
    wire  [1:0]       out_zero;
    wire  [1:0]       out_err;
    wire  [1:0][31:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_shifter #(.WIDTH(32), .STEP(1)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .in_amt(in_amt[0]), .in_mode(in_mode[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_carry(out_carry[0]), .out_zero(out_zero[0]), .out_err(out_err[0])
    );

    seq_shifter #(.WIDTH(32), .STEP(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .in_amt(in_amt[1]), .in_mode(in_mode[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_carry(out_carry[1]), .out_zero(out_zero[1]), .out_err(out_err[1])
    );

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int step_of(int u);
        return (u == 0) ? 1 : 4;
    endfunction

    // Edges after the accept edge before out_valid is seen high.
    function automatic int lat(int u, int a, logic [2:0] m);
        if (m > 3'd4 || a == 0) return 0;
        return (a + step_of(u) - 1) / step_of(u);
    endfunction

    function automatic logic [31:0] apply(logic [31:0] d, int n, logic [2:0] m);
        logic [63:0] dd;
        dd = {d, d};
        case (m)
            LSL:     return d << n;
            LSR:     return d >> n;
            ASR:     return 32'($signed(d) >>> n);
            ROL:     return 32'((dd << n) >> 32);
            ROR:     return 32'(dd >> n);
            default: return d;
        endcase
    endfunction

    // Reference result {err, carry, data}: whole shift at once, carry from the last step.
    function automatic logic [33:0] model(logic [31:0] d, int a, logic [2:0] m, int step);
        int          k;
        logic [31:0] pre;
        logic [31:0] post;
        logic        c;
        if (m > 3'd4) return {1'b1, 1'b0, d};
        if (a == 0) return {2'b00, d};
        k = a % step;
        if (k == 0) k = step;
        pre  = apply(d, a - k, m);
        post = apply(d, a, m);
        case (m)
            LSL:     c = pre[32-k];
            ROL:     c = post[k-1];
            ROR:     c = post[32-k];
            default: c = pre[k-1];
        endcase
        return {1'b0, c, post};
    endfunction

    task automatic send(int u, logic [31:0] d, logic [4:0] a, logic [2:0] m);
        int n;
        n = 0;
        while (in_ready[u] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("ready_timeout", 64'(in_ready[u]), 64'd1);
        in_valid[u] = 1'b1;
        in_data[u]  = d;
        in_amt[u]   = a;
        in_mode[u]  = m;
        @(posedge clk);
        @(negedge clk);
        in_valid[u] = 1'b0;
        in_data[u]  = $urandom;
        in_amt[u]   = 5'($urandom);
        in_mode[u]  = 3'($urandom);
    endtask

    task automatic collect(int u, int a, logic [2:0] m, logic [31:0] ed, logic ec, logic ee,
                           string tag);
        int n;
        n = 0;
        while (out_valid[u] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(lat(u, a, m)));
        check({tag, "_res"}, {out_err[u], out_carry[u], out_zero[u], out_data[u]},
              {ee, ec, (ed == 32'd0), ed});
    endtask

    task automatic drain_res(int u, int bp, logic [31:0] ed, logic ec, logic ee, string tag);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check({tag, "_hold"},
                  {in_ready[u], out_valid[u], out_err[u], out_carry[u], out_zero[u], out_data[u]},
                  {1'b0, 1'b1, ee, ec, (ed == 32'd0), ed});
        end
        out_ready[u] = 1'b1;
        @(negedge clk);
        out_ready[u] = 1'b0;
        check({tag, "_handoff"}, {in_ready[u], out_valid[u]}, 2'b10);
    endtask

    task automatic do_cmd(int u, logic [31:0] d, logic [4:0] a, logic [2:0] m,
                          logic [31:0] ed, logic ec, logic ee, int bp, string tag);
        send(u, d, a, m);
        collect(u, a, m, ed, ec, ee, tag);
        drain_res(u, bp, ed, ec, ee, tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [33:0] r;
        logic [33:0] r2;
        logic [31:0] d;
        logic [4:0]  a;
        logic [2:0]  m;
        int          u;
        logic        seen;

        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        in_data   = '0;
        in_amt    = '0;
        in_mode   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset",
                  {in_ready[i], out_valid[i], out_data[i], out_carry[i], out_zero[i], out_err[i]},
                  {1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0});
        end
        rst = 1'b0;
        @(negedge clk);

        // STEP=1 directed vectors
        do_cmd(0, 32'h8000_0001, 5'd1,  LSL, 32'h0000_0002, 1'b1, 1'b0, 0, "lsl1");
        do_cmd(0, 32'h8000_0000, 5'd31, ASR, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, "asr31");
        do_cmd(0, 32'h0000_00F0, 5'd4,  LSR, 32'h0000_000F, 1'b0, 1'b0, 0, "lsr4");
        do_cmd(0, 32'h8000_0000, 5'd1,  ROL, 32'h0000_0001, 1'b1, 1'b0, 0, "rol1");
        do_cmd(0, 32'h0000_0003, 5'd1,  ROR, 32'h8000_0001, 1'b1, 1'b0, 0, "ror1");
        do_cmd(0, 32'h1234_5678, 5'd0,  ROR, 32'h1234_5678, 1'b0, 1'b0, 0, "ror0");
        // STEP=4 directed vectors
        do_cmd(1, 32'hF000_0000, 5'd5,  LSR, 32'h0780_0000, 1'b0, 1'b0, 0, "s4_lsr5");
        do_cmd(1, 32'h1234_5678, 5'd8,  ROL, 32'h3456_7812, 1'b0, 1'b0, 0, "s4_rol8");
        do_cmd(1, 32'h0000_0001, 5'd31, LSL, 32'h8000_0000, 1'b0, 1'b0, 0, "s4_lsl31");
        do_cmd(1, 32'h8000_0000, 5'd1,  LSL, 32'h0000_0000, 1'b1, 1'b0, 0, "s4_zero");
        // Illegal mode, then a legal command clears err
        do_cmd(0, 32'hDEAD_BEEF, 5'd7,  3'b101, 32'hDEAD_BEEF, 1'b0, 1'b1, 0, "illegal");
        do_cmd(0, 32'h0000_0001, 5'd3,  LSL, 32'h0000_0008, 1'b0, 1'b0, 0, "after_ill");

        // Backpressure with a second command held by the producer
        r  = model(32'h0000_00FF, 6, ROR, 4);
        r2 = model(32'hA5A5_0F0F, 9, LSR, 4);
        send(1, 32'h0000_00FF, 5'd6, ROR);
        collect(1, 6, ROR, r[31:0], r[32], r[33], "bp_first");
        in_valid[1] = 1'b1;
        in_data[1]  = 32'hA5A5_0F0F;
        in_amt[1]   = 5'd9;
        in_mode[1]  = LSR;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold",
                  {in_ready[1], out_valid[1], out_err[1], out_carry[1], out_zero[1], out_data[1]},
                  {1'b0, 1'b1, r[33], r[32], (r[31:0] == 32'd0), r[31:0]});
        end
        out_ready[1] = 1'b1;
        @(negedge clk);
        out_ready[1] = 1'b0;
        check("bp_handoff", {in_ready[1], out_valid[1]}, 2'b10);
        @(posedge clk);
        @(negedge clk);
        in_valid[1] = 1'b0;
        collect(1, 9, LSR, r2[31:0], r2[32], r2[33], "bp_second");
        drain_res(1, 0, r2[31:0], r2[32], r2[33], "bp_second");

        // Randomised traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            u = int'($urandom_range(0, 1));
            d = $urandom;
            a = 5'($urandom);
            m = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            r = model(d, int'(a), m, step_of(u));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(u, d, a, m);
            collect(u, int'(a), m, r[31:0], r[32], r[33], "rnd");
            drain_res(u, int'($urandom_range(0, 3)), r[31:0], r[32], r[33], "rnd");
        end

        // Reset in the middle of a long shift discards the result
        send(0, 32'h8000_0000, 5'd31, ASR);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid",
              {in_ready[0], out_valid[0], out_data[0], out_carry[0], out_zero[0], out_err[0]},
              {1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0});
        rst  = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid[0]) seen = 1'b1;
        end
        check("rst_no_valid", 64'(seen), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
